// File: rtl/minas_pkg.sv
// Shared definitions for the minesweeper board datapath: widths, cell layout,
// client indices and the buffer arbiter state encoding.
package minas_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 6;

  localparam int BIT_BANDEIRA = 5;
  localparam int BIT_MINA     = 4;
  localparam int BIT_REVELADA = 3;
  localparam int CONT_MSB     = 2;
  localparam int CONT_LSB     = 0;

  localparam int CLI_CLEAR    = 0;
  localparam int CLI_MINAS    = 1;
  localparam int CLI_ABERTURA = 2;
  localparam int CLI_BANDEIRA = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arbitro_buffer_if.sv
// Client, VGA and buffer-side signals of the board buffer arbiter.
// slave is the arbiter's view; master is the view of whoever drives the clients and the buffer.
interface arbitro_buffer_if #(
  parameter int N_CLI  = 4,
  parameter int ADDR_W = minas_pkg::ADDR_W,
  parameter int DATA_W = minas_pkg::DATA_W
);

  logic [N_CLI-1:0]        cli_req;
  logic [N_CLI-1:0]        cli_we;
  logic [N_CLI*ADDR_W-1:0] cli_rd_addr;
  logic [N_CLI*ADDR_W-1:0] cli_wr_addr;
  logic [N_CLI*DATA_W-1:0] cli_wdata;
  logic [N_CLI-1:0]        cli_gnt;
  logic [N_CLI-1:0]        cli_rvalid;
  logic [DATA_W-1:0]       rdata;
  logic [ADDR_W-1:0]       vga_addr;
  logic                    vga_valid;
  logic [ADDR_W-1:0]       mem_read_addr;
  logic [ADDR_W-1:0]       mem_write_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic                    mem_we;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;

  modport slave (
    input  cli_req, cli_we, cli_rd_addr, cli_wr_addr, cli_wdata, vga_addr, mem_rdata,
    output cli_gnt, cli_rvalid, rdata, vga_valid,
    output mem_read_addr, mem_write_addr, mem_wdata, mem_we, busy
  );

  modport master (
    output cli_req, cli_we, cli_rd_addr, cli_wr_addr, cli_wdata, vga_addr, mem_rdata,
    input  cli_gnt, cli_rvalid, rdata, vga_valid,
    input  mem_read_addr, mem_write_addr, mem_wdata, mem_we, busy
  );

endinterface

// File: rtl/arbitro_buffer_prio_enc.sv
// Lowest-index-wins priority encoder: one-hot winner, its binary index and an any flag.
module prio_enc_onehot #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  output logic [N-1:0]     onehot_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  // Scan upward; the first set bit found is the winner.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && !any_o) begin
        onehot_o[i] = 1'b1;
        idx_o       = IDX_W'(i);
        any_o       = 1'b1;
      end else begin
        onehot_o[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/arbitro_buffer.sv
// Fixed-priority, grant-locked arbiter for the single board buffer; the VGA read
// path owns the buffer whenever no client holds a grant.
module arbitro_buffer
  import minas_pkg::*;
#(
  parameter int N_CLI  = 4,
  parameter int ADDR_W = minas_pkg::ADDR_W,
  parameter int DATA_W = minas_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input logic             clk,
  input logic             reset,
  arbitro_buffer_if.slave bus
);

  localparam int IDX_W = (N_CLI > 1) ? $clog2(N_CLI) : 1;

  arb_state_e              state_q;
  logic [IDX_W-1:0]        k_q;
  logic [N_CLI-1:0]        gnt_q;
  logic                    busy_q;
  logic [ADDR_W-1:0]       rd_addr_q;
  logic [ADDR_W-1:0]       wr_addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic                    we_q;
  logic [DATA_W-1:0]       rdata_q;
  logic [N_CLI-1:0]        rvalid_q;
  logic                    vga_valid_q;

  // Read-owner tag pipeline: valid, VGA-owned, client index.
  logic [RD_LAT:0]             pv_q;
  logic [RD_LAT:0]             pg_q;
  logic [RD_LAT:0][IDX_W-1:0]  pi_q;

  logic [N_CLI-1:0]  win_onehot_d;
  logic [IDX_W-1:0]  win_idx_d;
  logic              win_any_d;
  logic              sel_req_d;
  logic              sel_we_d;
  logic [ADDR_W-1:0] sel_rd_d;
  logic [ADDR_W-1:0] sel_wr_d;
  logic [DATA_W-1:0] sel_wd_d;
  logic [N_CLI-1:0]  rvalid_d;

  prio_enc_onehot #(.N(N_CLI), .IDX_W(IDX_W)) u_prio (
    .req_i    (bus.cli_req),
    .onehot_o (win_onehot_d),
    .idx_o    (win_idx_d),
    .any_o    (win_any_d)
  );

  // AND-OR mux of the owner's slices and decode of the tag leaving the read pipeline.
  always_comb begin
    sel_req_d = 1'b0;
    sel_we_d  = 1'b0;
    sel_rd_d  = '0;
    sel_wr_d  = '0;
    sel_wd_d  = '0;
    rvalid_d  = '0;
    for (int i = 0; i < N_CLI; i++) begin
      sel_req_d   = sel_req_d | (bus.cli_req[i] & (k_q == IDX_W'(i)));
      sel_we_d    = sel_we_d  | (bus.cli_we[i]  & (k_q == IDX_W'(i)));
      sel_rd_d    = sel_rd_d  | (bus.cli_rd_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{k_q == IDX_W'(i)}});
      sel_wr_d    = sel_wr_d  | (bus.cli_wr_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{k_q == IDX_W'(i)}});
      sel_wd_d    = sel_wd_d  | (bus.cli_wdata[i*DATA_W +: DATA_W]   & {DATA_W{k_q == IDX_W'(i)}});
      rvalid_d[i] = pv_q[RD_LAT] & ~pg_q[RD_LAT] & (pi_q[RD_LAT] == IDX_W'(i));
    end
  end

  // Arbitration FSM, registered buffer port and read-owner pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      rd_addr_q   <= '0;
      wr_addr_q   <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      rdata_q     <= '0;
      rvalid_q    <= '0;
      vga_valid_q <= 1'b0;
      pv_q        <= '0;
      pg_q        <= '0;
      pi_q        <= '0;
    end else begin
      for (int i = 1; i <= RD_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pg_q[i] <= pg_q[i-1];
        pi_q[i] <= pi_q[i-1];
      end
      pv_q[0]     <= 1'b1;
      rdata_q     <= bus.mem_rdata;
      rvalid_q    <= rvalid_d;
      vga_valid_q <= pv_q[RD_LAT] & pg_q[RD_LAT];

      case (state_q)
        IDLE: begin
          rd_addr_q <= bus.vga_addr;
          we_q      <= 1'b0;
          pg_q[0]   <= 1'b1;
          pi_q[0]   <= '0;
          if (win_any_d) begin
            state_q <= GRANT;
            gnt_q   <= win_onehot_d;
            k_q     <= win_idx_d;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (sel_req_d) begin
            rd_addr_q <= sel_rd_d;
            wr_addr_q <= sel_wr_d;
            wdata_q   <= sel_wd_d;
            we_q      <= sel_we_d;
            pg_q[0]   <= 1'b0;
            pi_q[0]   <= k_q;
          end else begin
            // Owner released: VGA takes the read port while the last write retires.
            state_q   <= GAP;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            we_q      <= 1'b0;
            rd_addr_q <= bus.vga_addr;
            pg_q[0]   <= 1'b1;
            pi_q[0]   <= '0;
          end
        end
        GAP: begin
          state_q   <= IDLE;
          we_q      <= 1'b0;
          rd_addr_q <= bus.vga_addr;
          pg_q[0]   <= 1'b1;
          pi_q[0]   <= '0;
        end
        default: begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          busy_q    <= 1'b0;
          we_q      <= 1'b0;
          rd_addr_q <= bus.vga_addr;
          pg_q[0]   <= 1'b1;
          pi_q[0]   <= '0;
        end
      endcase
    end
  end

  assign bus.cli_gnt        = gnt_q;
  assign bus.cli_rvalid     = rvalid_q;
  assign bus.rdata          = rdata_q;
  assign bus.vga_valid      = vga_valid_q;
  assign bus.mem_read_addr  = rd_addr_q;
  assign bus.mem_write_addr = wr_addr_q;
  assign bus.mem_wdata      = wdata_q;
  assign bus.mem_we         = we_q;
  assign bus.busy           = busy_q;

endmodule

// File: tb/tb_arbitro_buffer.sv
// Directed bench for arbitro_buffer with a one-cycle-latency buffer model
// preloaded so that cell a holds a[5:0].
module tb_arbitro_buffer;

  localparam int N_CLI  = 4;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 6;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  int   we_total = 0;
  int   we_base;
  logic mem_init = 1'b0;
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  arbitro_buffer_if #(.N_CLI(N_CLI), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  arbitro_buffer #(.N_CLI(N_CLI), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Buffer model: synchronous read and write, plus a running count of write strobes.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < (1 << ADDR_W); i++) mem[i] <= DATA_W'(i);
      mem_init      <= 1'b1;
      bus.mem_rdata <= '0;
    end else begin
      bus.mem_rdata <= mem[bus.mem_read_addr];
      if (bus.mem_we) begin
        mem[bus.mem_write_addr] <= bus.mem_wdata;
        we_total <= we_total + 1;
      end
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    reset  = 1'b1;
    bus.cli_req     = '0;
    bus.cli_we      = '0;
    bus.cli_rd_addr = '0;
    bus.cli_wr_addr = '0;
    bus.cli_wdata   = '0;
    bus.vga_addr    = 10'd37;
    repeat (3) tick();

    chk_eq("rst_gnt",    32'(bus.cli_gnt), 32'd0);
    chk_eq("rst_busy",   32'(bus.busy), 32'd0);
    chk_eq("rst_we",     32'(bus.mem_we), 32'd0);
    chk_eq("rst_raddr",  32'(bus.mem_read_addr), 32'd0);
    chk_eq("rst_vvalid", 32'(bus.vga_valid), 32'd0);
    chk_eq("rst_rvalid", 32'(bus.cli_rvalid), 32'd0);

    // VGA read in IDLE
    reset = 1'b0;
    tick();
    chk_eq("idle_raddr", 32'(bus.mem_read_addr), 32'd37);
    chk_eq("idle_we",    32'(bus.mem_we), 32'd0);
    tick();
    chk_eq("vga_lat_early", 32'(bus.vga_valid), 32'd0);
    tick();
    chk_eq("vga_valid", 32'(bus.vga_valid), 32'd1);
    chk_eq("vga_rdata", 32'(bus.rdata), 32'd37);

    // Simultaneous requests from clients 2 and 3
    bus.cli_rd_addr[2*ADDR_W +: ADDR_W] = 10'd100;
    bus.cli_rd_addr[3*ADDR_W +: ADDR_W] = 10'd70;
    bus.cli_req = 4'b1100;
    tick();
    chk_eq("prio_gnt",  32'(bus.cli_gnt), 32'h4);
    chk_eq("prio_busy", 32'(bus.busy), 32'd1);
    tick();
    chk_eq("c2_raddr", 32'(bus.mem_read_addr), 32'd100);
    bus.cli_req = 4'b1000;
    tick();
    chk_eq("gap_gnt",   32'(bus.cli_gnt), 32'd0);
    chk_eq("gap_busy",  32'(bus.busy), 32'd0);
    chk_eq("gap_raddr", 32'(bus.mem_read_addr), 32'd37);
    tick();
    chk_eq("idle_gnt",  32'(bus.cli_gnt), 32'd0);
    chk_eq("c2_rvalid", 32'(bus.cli_rvalid), 32'h4);
    chk_eq("c2_rdata",  32'(bus.rdata), 32'd36);
    chk_eq("c2_novga",  32'(bus.vga_valid), 32'd0);
    tick();
    chk_eq("c3_gnt", 32'(bus.cli_gnt), 32'h8);

    // Client 3 read-modify-write of cell 70
    we_base = we_total;
    tick();
    chk_eq("c3_raddr", 32'(bus.mem_read_addr), 32'd70);
    chk_eq("c3_we0",   32'(bus.mem_we), 32'd0);
    bus.cli_we[3] = 1'b1;
    bus.cli_wr_addr[3*ADDR_W +: ADDR_W] = 10'd70;
    bus.cli_wdata[3*DATA_W +: DATA_W]   = 6'b100101;
    tick();
    chk_eq("c3_we1",    32'(bus.mem_we), 32'd1);
    chk_eq("c3_waddr",  32'(bus.mem_write_addr), 32'd70);
    chk_eq("c3_wdata",  32'(bus.mem_wdata), 32'd37);
    bus.cli_we  = '0;
    bus.cli_req = '0;
    tick();
    chk_eq("c3_we_off",  32'(bus.mem_we), 32'd0);
    chk_eq("c3_rvalid",  32'(bus.cli_rvalid), 32'h8);
    chk_eq("c3_rdata",   32'(bus.rdata), 32'd6);
    chk_eq("c3_gnt_off", 32'(bus.cli_gnt), 32'd0);
    bus.vga_addr = 10'd70;
    tick();
    chk_eq("c3_rvalid_gap", 32'(bus.cli_rvalid), 32'h8);
    chk_eq("c3_gap_novga",  32'(bus.vga_valid), 32'd0);
    chk_eq("vga70_raddr",   32'(bus.mem_read_addr), 32'd70);
    tick();
    tick();
    chk_eq("wb_vvalid", 32'(bus.vga_valid), 32'd1);
    chk_eq("wb_rdata",  32'(bus.rdata), 32'd37);
    chk_eq("wb_count",  32'(we_total - we_base), 32'd1);

    // No preemption of client 2 by client 0
    bus.vga_addr = 10'd37;
    bus.cli_rd_addr[2*ADDR_W +: ADDR_W] = 10'd5;
    bus.cli_req = 4'b0100;
    tick();
    chk_eq("np_gnt0", 32'(bus.cli_gnt), 32'h4);
    bus.cli_req = 4'b0101;
    tick();
    chk_eq("np_gnt1", 32'(bus.cli_gnt), 32'h4);
    tick();
    chk_eq("np_gnt2", 32'(bus.cli_gnt), 32'h4);
    bus.cli_req = 4'b0001;
    tick();
    chk_eq("np_gap",  32'(bus.cli_gnt), 32'd0);
    tick();
    chk_eq("np_idle", 32'(bus.cli_gnt), 32'd0);
    tick();
    chk_eq("np_c0",   32'(bus.cli_gnt), 32'h1);

    // Reset in the middle of a client 0 write
    bus.cli_we[0] = 1'b1;
    bus.cli_rd_addr[0*ADDR_W +: ADDR_W] = 10'd9;
    bus.cli_wr_addr[0*ADDR_W +: ADDR_W] = 10'd200;
    bus.cli_wdata[0*DATA_W +: DATA_W]   = 6'd3;
    tick();
    chk_eq("mr_we_pre", 32'(bus.mem_we), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_eq("mr_we",   32'(bus.mem_we), 32'd0);
    chk_eq("mr_gnt",  32'(bus.cli_gnt), 32'd0);
    chk_eq("mr_busy", 32'(bus.busy), 32'd0);
    bus.cli_req = '0;
    bus.cli_we  = '0;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_eq("mr_no_rvalid", 32'(bus.cli_rvalid), 32'd0);
    end

    // Request withdrawn on the grant cycle
    we_base = we_total;
    bus.cli_we[1] = 1'b1;
    bus.cli_wr_addr[1*ADDR_W +: ADDR_W] = 10'd300;
    bus.cli_wdata[1*DATA_W +: DATA_W]   = 6'd7;
    bus.cli_req = 4'b0010;
    tick();
    chk_eq("z_gnt",    32'(bus.cli_gnt), 32'h2);
    chk_eq("z_we_gnt", 32'(bus.mem_we), 32'd0);
    bus.cli_req = '0;
    bus.cli_we  = '0;
    tick();
    chk_eq("z_gap_gnt",   32'(bus.cli_gnt), 32'd0);
    chk_eq("z_gap_busy",  32'(bus.busy), 32'd0);
    chk_eq("z_gap_we",    32'(bus.mem_we), 32'd0);
    chk_eq("z_gap_raddr", 32'(bus.mem_read_addr), 32'd37);
    tick();
    tick();
    chk_eq("z_vga_valid", 32'(bus.vga_valid), 32'd1);
    chk_eq("z_vga_rdata", 32'(bus.rdata), 32'd37);
    chk_eq("z_wcount",    32'(we_total - we_base), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
